// File: rtl/framebuffer_mono_rop.sv
// 1-bpp framebuffer: one single-port BRAM behind a command/response port with
// unaligned 8-pixel access, column reads, raster-op writes, fill and clipping.
module framebuffer_mono_rop #(
  parameter int H_PIXELS = 128,
  parameter int V_PIXELS = 64,
  parameter int XW = 8,
  parameter int YW = 8
) (
  input  logic          clk,
  input  logic          rst,
  output logic          init_done,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [1:0]    cmd_rop,
  input  logic [XW-1:0] cmd_x,
  input  logic [YW-1:0] cmd_y,
  input  logic [7:0]    cmd_data,
  output logic          rsp_valid,
  output logic [7:0]    rsp_data
);
  localparam int HB = H_PIXELS / 8;
  localparam int DEPTH = HB * V_PIXELS;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [1:0] OP_RD_H = 2'd0, OP_RD_COL = 2'd1, OP_WRITE = 2'd2;
  localparam logic [1:0] ROP_COPY = 2'd0, ROP_OR = 2'd1, ROP_ANDN = 2'd2;

  typedef enum logic [3:0] {
    S_CLEAR, S_IDLE, S_RD_A, S_RD_B, S_COL, S_RMW_A, S_RMW_B, S_WR_A, S_WR_B, S_FILL, S_RESP
  } state_t;

  state_t state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic [1:0]    rop_reg, rop_next;
  logic [XW-1:0] x_reg, x_next;
  logic [YW-1:0] y_reg, y_next;
  logic [7:0]    data_reg, data_next, b0_reg, b0_next, b1_reg, b1_next;
  logic [7:0]    col_reg, col_next, result_reg, result_next;
  logic [7:0]    rsp_data_reg;
  logic          rsp_valid_reg, init_done_reg;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_data, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    rd_data <= mem[mem_addr];
  end

  function automatic logic [AW-1:0] byte_addr(input int xx, input int yy);
    return AW'(yy * HB + xx / 8);
  endfunction

  logic [2:0]    sub;
  logic [AW-1:0] base_addr, next_addr;
  logic          hi_clip, row_ok, next_row_ok, col_bit, accept;
  logic [7:0]    b1_in, rd_merge;
  logic [15:0]   old_w, din_w, mask_w, rop_w, new_w;

  assign sub         = x_reg[2:0];
  assign base_addr   = byte_addr(int'(x_reg), int'(y_reg));
  // The second byte of an unaligned access may fall past the row end; it is
  // then neither written nor read, and never wraps into the next row.
  assign hi_clip     = (int'(x_reg) / 8 + 1) >= HB;
  assign next_addr   = hi_clip ? base_addr : base_addr + AW'(1);
  assign row_ok      = (int'(y_reg) + int'(cnt_reg[2:0])) < V_PIXELS;
  assign next_row_ok = (int'(y_reg) + int'(cnt_reg[2:0]) + 1) < V_PIXELS;
  assign col_bit     = row_ok & rd_data[3'd7 - sub];
  assign b1_in       = hi_clip ? 8'h00 : rd_data;
  assign rd_merge    = 8'(({b0_reg, b1_in} << sub) >> 8);
  assign accept      = cmd_valid && cmd_ready;

  always_comb begin
    old_w  = {b0_reg, b1_reg};
    din_w  = {data_reg, 8'h00} >> sub;
    mask_w = 16'hFF00 >> sub;
    case (rop_reg)
      ROP_OR:   rop_w = old_w | din_w;
      ROP_ANDN: rop_w = old_w & ~din_w;
      ROP_COPY: rop_w = din_w;
      default:  rop_w = old_w ^ din_w;
    endcase
    new_w = (old_w & ~mask_w) | (rop_w & mask_w);
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    rop_next    = rop_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    data_next   = data_reg;
    b0_next     = b0_reg;
    b1_next     = b1_reg;
    col_next    = col_reg;
    result_next = result_reg;
    mem_we      = 1'b0;
    mem_addr    = base_addr;
    mem_wdata   = 8'h00;
    case (state_reg)
      S_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = cnt_reg;
        cnt_next = cnt_reg + AW'(1);
        if (cnt_reg == LAST) begin
          cnt_next   = '0;
          state_next = S_IDLE;
        end
      end
      S_IDLE: begin
        // First byte is read straight from the port so it lands the next cycle.
        mem_addr = byte_addr(int'(cmd_x), int'(cmd_y));
        if (accept) begin
          rop_next    = cmd_rop;
          x_next      = cmd_x;
          y_next      = cmd_y;
          data_next   = cmd_data;
          cnt_next    = '0;
          col_next    = 8'h00;
          result_next = 8'h00;
          if (int'(cmd_x) >= H_PIXELS || int'(cmd_y) >= V_PIXELS) state_next = S_RESP;
          else if (cmd_op == OP_RD_H) state_next = S_RD_A;
          else if (cmd_op == OP_RD_COL) state_next = S_COL;
          else if (cmd_op == OP_WRITE)
            state_next = (cmd_x[2:0] == 3'd0 && cmd_rop == ROP_COPY) ? S_WR_A : S_RMW_A;
          else state_next = S_FILL;
        end
      end
      S_RD_A: begin
        b0_next = rd_data;
        if (sub == 3'd0) begin
          result_next = rd_data;
          state_next  = S_RESP;
        end else begin
          mem_addr   = next_addr;
          state_next = S_RD_B;
        end
      end
      S_RD_B: begin
        result_next = rd_merge;
        state_next  = S_RESP;
      end
      S_COL: begin
        col_next = {col_reg[6:0], col_bit};
        mem_addr = next_row_ok ? byte_addr(int'(x_reg), int'(y_reg) + int'(cnt_reg[2:0]) + 1)
                               : base_addr;
        cnt_next = cnt_reg + AW'(1);
        if (cnt_reg[2:0] == 3'd7) begin
          result_next = {col_reg[6:0], col_bit};
          cnt_next    = '0;
          state_next  = S_RESP;
        end
      end
      S_RMW_A: begin
        b0_next = rd_data;
        if (sub == 3'd0) state_next = S_WR_A;
        else begin
          mem_addr   = next_addr;
          state_next = S_RMW_B;
        end
      end
      S_RMW_B: begin
        b1_next    = rd_data;
        state_next = S_WR_A;
      end
      S_WR_A: begin
        mem_we     = 1'b1;
        mem_wdata  = new_w[15:8];
        state_next = (sub == 3'd0) ? S_RESP : S_WR_B;
      end
      S_WR_B: begin
        mem_we     = !hi_clip;
        mem_addr   = next_addr;
        mem_wdata  = new_w[7:0];
        state_next = S_RESP;
      end
      S_FILL: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_reg;
        mem_wdata = data_reg;
        cnt_next  = cnt_reg + AW'(1);
        if (cnt_reg == LAST) begin
          cnt_next   = '0;
          state_next = S_RESP;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_CLEAR;
    endcase
    if (rst) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_CLEAR;
      cnt_reg       <= '0;
      init_done_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= 8'h00;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      init_done_reg <= init_done_reg | (state_reg == S_IDLE);
      rsp_valid_reg <= (state_reg == S_RESP);
      if (state_reg == S_RESP) rsp_data_reg <= result_reg;
    end
  end

  always_ff @(posedge clk) begin
    rop_reg    <= rop_next;
    x_reg      <= x_next;
    y_reg      <= y_next;
    data_reg   <= data_next;
    b0_reg     <= b0_next;
    b1_reg     <= b1_next;
    col_reg    <= col_next;
    result_reg <= result_next;
  end

  assign init_done = init_done_reg;
  assign cmd_ready = (state_reg == S_IDLE) && init_done_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
endmodule
